// File: rtl/axi_fifo_pkg.sv
// rtl/axi_fifo_pkg.sv - shared response codes, FSM state types and clog2 helper for axi_fifo_mux_data
package axi_fifo_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  // Smallest r with 2**r >= n (0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_fifo_ch_buf.sv
// rtl/axi_fifo_ch_buf.sv - synchronous show-ahead sample FIFO, one per stream channel
module axi_fifo_ch_buf
  import axi_fifo_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  // DEPTH is a power of two, so the count MSB alone marks full.
  assign full    = cnt_q[AW];
  assign empty   = (cnt_q == '0);
  assign head    = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next pointers and occupancy; simultaneous push and pop leave the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/count registers; clearing them empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Sample storage, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/axi_fifo_mux_data.sv
// rtl/axi_fifo_mux_data.sv - AXI4 read-only slave draining per-channel stream FIFOs (AXI_FIFO_SIGN_EXT_EN selects sign extension)
module axi_fifo_mux_data
  import axi_fifo_pkg::*;
#(
  parameter int S_AXI_ID_WIDTH    = 1,
  parameter int S_AXI_DATA_WIDTH  = 32,
  parameter int S_AXI_ADDR_WIDTH  = 8,
  parameter int S_AXIS_DATA_WIDTH = 24,
  parameter int NUM_CH            = 4,
  parameter int CH_SEL_LSB        = 4,
  parameter int FIFO_DEPTH        = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [S_AXI_ID_WIDTH-1:0]           s_axi_awid,
  input  logic [S_AXI_ADDR_WIDTH-1:0]         s_axi_awaddr,
  input  logic [7:0]                          s_axi_awlen,
  input  logic [2:0]                          s_axi_awsize,
  input  logic [1:0]                          s_axi_awburst,
  input  logic                                s_axi_awvalid,
  output logic                                s_axi_awready,
  input  logic [S_AXI_DATA_WIDTH-1:0]         s_axi_wdata,
  input  logic [S_AXI_DATA_WIDTH/8-1:0]       s_axi_wstrb,
  input  logic                                s_axi_wlast,
  input  logic                                s_axi_wvalid,
  output logic                                s_axi_wready,
  output logic [S_AXI_ID_WIDTH-1:0]           s_axi_bid,
  output logic [1:0]                          s_axi_bresp,
  output logic                                s_axi_bvalid,
  input  logic                                s_axi_bready,
  input  logic [S_AXI_ID_WIDTH-1:0]           s_axi_arid,
  input  logic [S_AXI_ADDR_WIDTH-1:0]         s_axi_araddr,
  input  logic [7:0]                          s_axi_arlen,
  input  logic [2:0]                          s_axi_arsize,
  input  logic [1:0]                          s_axi_arburst,
  input  logic                                s_axi_arvalid,
  output logic                                s_axi_arready,
  output logic [S_AXI_ID_WIDTH-1:0]           s_axi_rid,
  output logic [S_AXI_DATA_WIDTH-1:0]         s_axi_rdata,
  output logic [1:0]                          s_axi_rresp,
  output logic                                s_axi_rlast,
  output logic                                s_axi_rvalid,
  input  logic                                s_axi_rready,
  input  logic [NUM_CH-1:0]                   s_axis_tvalid,
  output logic [NUM_CH-1:0]                   s_axis_tready,
  input  logic [NUM_CH*S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]                   s_axis_tlast
);

  localparam int SW      = S_AXIS_DATA_WIDTH;
  localparam int DW      = S_AXI_DATA_WIDTH;
  localparam int CH_BITS = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int NSLOT   = 1 << CH_BITS;

  // Every output is forced low while reset is held.
  logic live;
  assign live = !rst;

  // Slots beyond NUM_CH exist only so any decoded index is in range.
  logic [SW-1:0]    head [NSLOT];
  logic [NSLOT-1:0] empty_v;
  logic [NSLOT-1:0] pop_v;

  for (genvar k = 0; k < NSLOT; k++) begin : g_ch
    if (k < NUM_CH) begin : g_buf
      logic full_k;
      axi_fifo_ch_buf #(.W(SW), .DEPTH(FIFO_DEPTH)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (s_axis_tvalid[k] && s_axis_tready[k]),
        .din   (s_axis_tdata[k*SW +: SW]),
        .pop   (pop_v[k]),
        .full  (full_k),
        .empty (empty_v[k]),
        .head  (head[k])
      );
      assign s_axis_tready[k] = live && !full_k;
    end else begin : g_none
      assign empty_v[k] = 1'b1;
      assign head[k]    = '0;
    end
  end

  rd_state_t                 rs_q, rs_d;
  logic [S_AXI_ID_WIDTH-1:0] rid_q, rid_d;
  logic [7:0]                len_q, len_d;
  logic [7:0]                beat_q, beat_d;
  logic [CH_BITS-1:0]        ch_q, ch_d;
  logic                      r_valid_int, r_last_int, r_hs;
  logic [SW-1:0]             head_sel;
  logic [DW-1:0]             head_ext;

  assign head_sel = head[ch_q];
`ifdef AXI_FIFO_SIGN_EXT_EN
  assign head_ext = {{(DW-SW){head_sel[SW-1]}}, head_sel};
`else
  assign head_ext = {{(DW-SW){1'b0}}, head_sel};
`endif

  assign r_valid_int = ((rs_q == R_DATA) && !empty_v[ch_q]) || (rs_q == R_ERR);
  assign r_last_int  = r_valid_int && (beat_q == len_q);
  assign r_hs        = live && r_valid_int && s_axi_rready;

  assign s_axi_arready = live && (rs_q == R_ADDR);
  assign s_axi_rvalid  = live && r_valid_int;
  assign s_axi_rlast   = live && r_last_int;
  assign s_axi_rresp   = (live && rs_q == R_ERR) ? AXI_RESP_DECERR : AXI_RESP_OKAY;
  assign s_axi_rdata   = (live && rs_q == R_DATA && !empty_v[ch_q]) ? head_ext : '0;
  assign s_axi_rid     = live ? rid_q : '0;

  // Only the selected channel pops, and only on a data-phase handshake.
  always_comb begin
    pop_v = '0;
    if (r_hs && rs_q == R_DATA) pop_v[ch_q] = 1'b1;
  end

  // Read FSM next state: capture the request, one arready cycle, then stream or error beats.
  always_comb begin
    rs_d   = rs_q;
    rid_d  = rid_q;
    len_d  = len_q;
    beat_d = beat_q;
    ch_d   = ch_q;
    case (rs_q)
      R_IDLE: if (s_axi_arvalid) begin
        rs_d  = R_ADDR;
        rid_d = s_axi_arid;
        len_d = s_axi_arlen;
        ch_d  = s_axi_araddr[CH_SEL_LSB +: CH_BITS];
      end
      R_ADDR: begin
        beat_d = '0;
        rs_d   = (32'(ch_q) < NUM_CH) ? R_DATA : R_ERR;
      end
      R_DATA, R_ERR: if (r_hs) begin
        beat_d = beat_q + 8'd1;
        if (r_last_int) rs_d = R_IDLE;
      end
      default: rs_d = R_IDLE;
    endcase
  end

  // Read FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q   <= R_IDLE;
      rid_q  <= '0;
      len_q  <= '0;
      beat_q <= '0;
      ch_q   <= '0;
    end else begin
      rs_q   <= rs_d;
      rid_q  <= rid_d;
      len_q  <= len_d;
      beat_q <= beat_d;
      ch_q   <= ch_d;
    end
  end

  wr_state_t                 ws_q, ws_d;
  logic [S_AXI_ID_WIDTH-1:0] bid_q, bid_d;

  assign s_axi_awready = live && (ws_q == W_IDLE);
  assign s_axi_wready  = live && (ws_q == W_DATA);
  assign s_axi_bvalid  = live && (ws_q == W_RESP);
  assign s_axi_bresp   = (live && ws_q == W_RESP) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign s_axi_bid     = live ? bid_q : '0;

  // Write FSM next state: accept address, sink data beats, answer SLVERR.
  always_comb begin
    ws_d  = ws_q;
    bid_d = bid_q;
    case (ws_q)
      W_IDLE: if (s_axi_awvalid) begin
        ws_d  = W_DATA;
        bid_d = s_axi_awid;
      end
      W_DATA:  if (s_axi_wvalid && s_axi_wlast) ws_d = W_RESP;
      W_RESP:  if (s_axi_bready) ws_d = W_IDLE;
      default: ws_d = W_IDLE;
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_q  <= W_IDLE;
      bid_q <= '0;
    end else begin
      ws_q  <= ws_d;
      bid_q <= bid_d;
    end
  end

endmodule
